// File: rtl/edge_filter_pkg.sv
// Shared types and helpers for the streaming Sobel edge filter.
package edge_filter_pkg;

    typedef enum logic [1:0] {
        GREY = 2'd0,
        GX   = 2'd1,
        GY   = 2'd2,
        MAG  = 2'd3
    } mode_e;

    // Centre-tap weight of the Sobel kernels is 2, i.e. one left shift.
    localparam int SOBEL_MID_SH = 1;

    function automatic logic [31:0] sat_shift(
        input logic [31:0] val,
        input logic [31:0] sh,
        input int          pix_w
    );
        logic [31:0] v;
        logic [31:0] mx;
        v  = val >> sh;
        mx = (32'd1 << pix_w) - 32'd1;
        return (v > mx) ? mx : v;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of grey pixels, addressed by column; read returns the old
// content in the same cycle that a write is issued.
module line_buffer
    import edge_filter_pkg::*;
#(
    parameter int PIX_W = 12,
    parameter int DEPTH = 640
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [PIX_W-1:0]         i_wdata,
    output logic [PIX_W-1:0]         o_rdata
);

    logic [PIX_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/edge_filter_pipeline.sv
// Streaming 3x3 Sobel edge filter: S1 grey, S2 window/sums, S3 abs/scale.
// Define EDGE_FILTER_THRESHOLD_EN to add the binary i_threshold output stage.
module edge_filter_pipeline
    import edge_filter_pkg::*;
#(
    parameter int PIX_W = 12,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int ACC_W = PIX_W + 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic                     i_sof,
    input  logic [PIX_W-1:0]         i_red,
    input  logic [PIX_W-1:0]         i_green,
    input  logic [PIX_W-1:0]         i_blue,
    input  logic [1:0]               i_mode,
    input  logic [$clog2(ACC_W)-1:0] i_shift_amt,
`ifdef EDGE_FILTER_THRESHOLD_EN
    input  logic [PIX_W-1:0]         i_threshold,
`endif
    output logic [PIX_W-1:0]         o_red,
    output logic [PIX_W-1:0]         o_green,
    output logic [PIX_W-1:0]         o_blue,
    output logic                     o_valid
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int GW    = PIX_W + 3;
    localparam int SW    = PIX_W + 4;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed(SW'(p));
    endfunction

    logic [ROW_W-1:0] r_row, r_s1_row;
    logic [COL_W-1:0] r_col, r_s1_col;
    mode_e            r_mode, r_s1_mode, r_s2_mode;
    logic             r_s1_valid, r_s2_valid, r_s3_valid;
    logic [PIX_W-1:0] r_s1_grey, r_s2_grey, r_s3_pix;
    logic [PIX_W-1:0] r_wa [3];
    logic [PIX_W-1:0] r_wb [3];
    logic signed [SW-1:0] r_s2_gx, r_s2_gy;
    logic             r_s2_border;

    logic [GW-1:0]    w_b2, w_g3, w_r3, w_gsum;
    logic [PIX_W-1:0] w_grey;
    logic [ROW_W-1:0] w_pos_row;
    logic [COL_W-1:0] w_pos_col;
    mode_e            w_mode;
    logic [PIX_W-1:0] w_lb0_rd, w_lb1_rd;
    logic [PIX_W-1:0] w_new [3];
    logic signed [SW-1:0] w_gx, w_gy;
    logic             w_border;
    logic [ACC_W-1:0] w_abs_gx, w_abs_gy, w_val;
    logic [PIX_W-1:0] w_sat, w_edge, w_out;

    assign w_b2   = GW'(i_blue) << 1;
    assign w_g3   = (GW'(i_green) << 1) + GW'(i_green);
    assign w_r3   = (GW'(i_red) << 1) + GW'(i_red);
    assign w_gsum = w_b2 + w_g3 + w_r3;
    assign w_grey = PIX_W'(w_gsum >> 3);

    assign w_pos_row = i_sof ? '0 : r_row;
    assign w_pos_col = i_sof ? '0 : r_col;
    assign w_mode    = i_sof ? mode_e'(i_mode) : r_mode;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_row      <= '0;
            r_col      <= '0;
            r_mode     <= GREY;
            r_s1_valid <= 1'b0;
            r_s1_grey  <= '0;
            r_s1_row   <= '0;
            r_s1_col   <= '0;
            r_s1_mode  <= GREY;
        end else begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_grey <= w_grey;
                r_s1_row  <= w_pos_row;
                r_s1_col  <= w_pos_col;
                r_s1_mode <= w_mode;
                r_mode    <= w_mode;
                r_col     <= (w_pos_col == COL_MAX) ? '0 : w_pos_col + 1'b1;
                if (w_pos_col == COL_MAX && w_pos_row != ROW_MAX)
                    r_row <= w_pos_row + 1'b1;
                else
                    r_row <= w_pos_row;
            end
        end
    end

    line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb0 (
        .i_clk   (i_clk),
        .i_we    (r_s1_valid),
        .i_addr  (r_s1_col),
        .i_wdata (r_s1_grey),
        .o_rdata (w_lb0_rd)
    );

    line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb1 (
        .i_clk   (i_clk),
        .i_we    (r_s1_valid),
        .i_addr  (r_s1_col),
        .i_wdata (w_lb0_rd),
        .o_rdata (w_lb1_rd)
    );

    // Window rows: 0 = two lines up, 1 = previous line, 2 = current line.
    assign w_new[0] = w_lb1_rd;
    assign w_new[1] = w_lb0_rd;
    assign w_new[2] = r_s1_grey;

    assign w_gx = (ext(w_new[0]) + (ext(w_new[1]) <<< SOBEL_MID_SH) + ext(w_new[2]))
                - (ext(r_wa[0])  + (ext(r_wa[1])  <<< SOBEL_MID_SH) + ext(r_wa[2]));
    assign w_gy = (ext(r_wa[2]) + (ext(r_wb[2]) <<< SOBEL_MID_SH) + ext(w_new[2]))
                - (ext(r_wa[0]) + (ext(r_wb[0]) <<< SOBEL_MID_SH) + ext(w_new[0]));

    // Centre sits at (row-1, col-1); it only leaves the border band for row,col >= 2.
    assign w_border = (r_s1_row < ROW_W'(2)) || (r_s1_col < COL_W'(2));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s2_valid  <= 1'b0;
            r_wa        <= '{default: '0};
            r_wb        <= '{default: '0};
            r_s2_gx     <= '0;
            r_s2_gy     <= '0;
            r_s2_grey   <= '0;
            r_s2_border <= 1'b1;
            r_s2_mode   <= GREY;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_wa        <= r_wb;
                r_wb        <= w_new;
                r_s2_gx     <= w_gx;
                r_s2_gy     <= w_gy;
                r_s2_grey   <= r_s1_grey;
                r_s2_border <= w_border;
                r_s2_mode   <= r_s1_mode;
            end
        end
    end

    assign w_abs_gx = r_s2_gx[SW-1] ? ACC_W'($unsigned(-r_s2_gx)) : ACC_W'($unsigned(r_s2_gx));
    assign w_abs_gy = r_s2_gy[SW-1] ? ACC_W'($unsigned(-r_s2_gy)) : ACC_W'($unsigned(r_s2_gy));

    always_comb begin
        w_val = '0;
        unique case (r_s2_mode)
            GREY: w_val = ACC_W'(r_s2_grey);
            GX:   w_val = w_abs_gx;
            GY:   w_val = w_abs_gy;
            MAG:  w_val = w_abs_gx + w_abs_gy;
        endcase
    end

    assign w_sat = PIX_W'(sat_shift(32'(w_val), 32'(i_shift_amt), PIX_W));

`ifdef EDGE_FILTER_THRESHOLD_EN
    assign w_edge = (w_sat >= i_threshold) ? '1 : '0;
`else
    assign w_edge = w_sat;
`endif

    assign w_out = (r_s2_mode == GREY) ? w_sat : (r_s2_border ? '0 : w_edge);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s3_valid <= 1'b0;
            r_s3_pix   <= '0;
        end else begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) r_s3_pix <= w_out;
        end
    end

    assign o_red   = r_s3_pix;
    assign o_green = r_s3_pix;
    assign o_blue  = r_s3_pix;
    assign o_valid = r_s3_valid;

endmodule

// File: tb/tb_edge_filter_pipeline.sv
// Scoreboard bench for edge_filter_pipeline on an 8x6 image.
module tb_edge_filter_pipeline;

    localparam int PW   = 12;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int AW   = PW + 4;
    localparam int SHW  = $clog2(AW);
    localparam int MAXV = 4095;

    logic           clk   = 1'b0;
    logic           rst   = 1'b1;
    logic           valid = 1'b0;
    logic           sof   = 1'b0;
    logic [PW-1:0]  red   = '0;
    logic [PW-1:0]  green = '0;
    logic [PW-1:0]  blue  = '0;
    logic [1:0]     mode  = '0;
    logic [SHW-1:0] shamt = '0;
`ifdef EDGE_FILTER_THRESHOLD_EN
    logic [PW-1:0]  thr   = 12'd300;
`endif
    logic [PW-1:0]  o_red, o_green, o_blue;
    logic           o_valid;

    edge_filter_pipeline #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .i_sof       (sof),
        .i_red       (red),
        .i_green     (green),
        .i_blue      (blue),
        .i_mode      (mode),
        .i_shift_amt (shamt),
`ifdef EDGE_FILTER_THRESHOLD_EN
        .i_threshold (thr),
`endif
        .o_red       (o_red),
        .o_green     (o_green),
        .o_blue      (o_blue),
        .o_valid     (o_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   img[H][W];
    int   m_row = 0;
    int   m_col = 0;
    int   m_mode = 0;
    int   checks = 0;
    int   failures = 0;

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Expected output for the pixel just stored at (m_row, m_col).
    function automatic int model(input int gv);
        int k, kc, cr, cc, gx, gy, v, s;
        if (m_mode == 0) begin
            v = gv;
        end else begin
            k  = m_row * W + m_col;
            kc = k - W - 1;
            if (kc < 0) return 0;
            cr = kc / W;
            cc = kc % W;
            if (cr == 0 || cr == H - 1 || cc == 0 || cc == W - 1) return 0;
            gx = (img[cr-1][cc+1] + 2 * img[cr][cc+1] + img[cr+1][cc+1])
               - (img[cr-1][cc-1] + 2 * img[cr][cc-1] + img[cr+1][cc-1]);
            gy = (img[cr+1][cc-1] + 2 * img[cr+1][cc] + img[cr+1][cc+1])
               - (img[cr-1][cc-1] + 2 * img[cr-1][cc] + img[cr-1][cc+1]);
            if (m_mode == 1) v = iabs(gx);
            else if (m_mode == 2) v = iabs(gy);
            else v = iabs(gx) + iabs(gy);
        end
        s = v >> int'(shamt);
        if (s > MAXV) s = MAXV;
`ifdef EDGE_FILTER_THRESHOLD_EN
        if (m_mode != 0) s = (s >= int'(thr)) ? MAXV : 0;
`endif
        return s;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && o_valid) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_out got=%0d exp=none", o_red);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                assert (o_red === 12'(e.val)) else begin
                    failures++;
                    $error("FAIL pix_red got=%0d exp=%0d", o_red, e.val);
                end
                checks++;
                assert (o_green === 12'(e.val) && o_blue === 12'(e.val)) else begin
                    failures++;
                    $error("FAIL pix_gb got=%0d/%0d exp=%0d", o_green, o_blue, e.val);
                end
                checks++;
                assert (cyc === e.cyc) else begin
                    failures++;
                    $error("FAIL latency got_cyc=%0d exp_cyc=%0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input int g, input int b, input bit s);
        exp_t e;
        int   gv;
        red   = 12'(r);
        green = 12'(g);
        blue  = 12'(b);
        sof   = s;
        valid = 1'b1;
        if (s) begin
            m_row  = 0;
            m_col  = 0;
            m_mode = int'(mode);
        end
        gv = (2 * b + 3 * g + 3 * r) >> 3;
        img[m_row][m_col] = gv;
        e.val = model(gv);
        e.cyc = cyc + 3;
        sb.push_back(e);
        if (m_col == W - 1) begin
            m_col = 0;
            if (m_row < H - 1) m_row++;
        end else begin
            m_col++;
        end
        tick();
        valid = 1'b0;
        sof   = 1'b0;
    endtask

    task automatic send_frame(input int md, input int lo, input int hi,
                              input bit gaps, input int npix,
                              input int chg_row, input int chg_mode);
        mode = 2'(md);
        for (int i = 0; i < npix; i++) begin
            int rr, cc, v;
            rr = i / W;
            cc = i % W;
            if (rr == chg_row && cc == 0) mode = 2'(chg_mode);
            v = (cc < 4) ? lo : hi;
            drive(v, v, v, i == 0);
            if (gaps && (i % 3 == 1)) tick();
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL drain got_left=%0d exp=0", sb.size());
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        assert (o_valid === 1'b0) else begin
            failures++;
            $error("FAIL rst_valid got=%0b exp=0", o_valid);
        end
        checks++;
        assert (o_red === '0 && o_green === '0 && o_blue === '0) else begin
            failures++;
            $error("FAIL rst_pix got=%0d exp=0", o_red);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Grey path with bubbles, including unequal channels and full scale
        mode  = 2'd0;
        shamt = '0;
        drive(800, 800, 800, 1'b1);
        tick();
        drive(800, 800, 800, 1'b0);
        tick();
        tick();
        drive(800, 800, 800, 1'b0);
        drive(800, 800, 800, 1'b0);
        tick();
        drive(800, 800, 800, 1'b0);
        drive(100, 200, 400, 1'b0);
        drive(4095, 4095, 4095, 1'b0);
        drain();

        // Flat frame in MAG mode
        send_frame(3, 1000, 1000, 1'b0, W * H, -1, 0);
        drain();

        // Vertical edge, GX, with bubbles; then shift by 2
        send_frame(1, 0, 100, 1'b1, W * H, -1, 0);
        drain();
        shamt = SHW'(2);
        send_frame(1, 0, 100, 1'b0, W * H, -1, 0);
        drain();
        shamt = '0;

        // Strong edge saturates in MAG; GY sees nothing
        send_frame(3, 0, 4000, 1'b0, W * H, -1, 0);
        drain();
        send_frame(2, 0, 4000, 1'b0, W * H, -1, 0);
        drain();

        // Mode change mid-frame applies from the next frame only
        send_frame(1, 0, 100, 1'b0, W * H, 2, 2);
        send_frame(2, 0, 100, 1'b0, W * H, -1, 0);
        drain();

        // Reset in the middle of row 3
        send_frame(1, 0, 100, 1'b0, 3 * W + 2, -1, 0);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        checks++;
        assert (o_valid === 1'b0) else begin
            failures++;
            $error("FAIL midrst_valid got=%0b exp=0", o_valid);
        end
        checks++;
        assert (o_red === '0) else begin
            failures++;
            $error("FAIL midrst_pix got=%0d exp=0", o_red);
        end
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_row  = 0;
        m_col  = 0;
        m_mode = 0;
        tick();

        // Mode latch back at GREY; i_mode ignored without i_sof
        mode = 2'd1;
        for (int i = 0; i < 10; i++) drive(300, 300, 300, 1'b0);
        drain();
        send_frame(1, 0, 100, 1'b0, W * H, -1, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
